// File: rtl/mem_access_ctrl.sv
// Memory-access sequencer: one prepared load/store becomes one req/ack bus transaction.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN (abort with cause 11).
module mem_access_ctrl #(
   parameter int TIMEOUT_W      = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [1:0]  mem_width_i,
   input  logic        mem_unsigned_i,
   input  logic [1:0]  mem_byte_idx_i,
   input  logic [31:0] mem_word_addr_i,
   input  logic [31:0] mem_write_data_i,
   input  logic [3:0]  mem_strobe_i,
   input  logic        mem_illegal_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] load_data_o,
   output logic        fault_o,
   output logic [1:0]  fault_cause_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_strb_o,
   input  logic        bus_ack_i,
   input  logic        bus_err_i,
   input  logic [31:0] bus_rdata_i
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t      state;
   logic [1:0]  width_q;
   logic        unsigned_q;
   logic [1:0]  idx_q;
   logic        is_read_q;
   logic [31:0] byte_shift;
   logic [31:0] half_shift;
   logic [31:0] load_ext;
   logic        bad_access;

`ifdef MEM_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] WD_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
   logic [TIMEOUT_W-1:0] wd_cnt;
`endif

   assign busy_o     = (state != IDLE);
   assign bad_access = mem_illegal_i || (mem_read_i && mem_write_i) || (mem_width_i == 2'b11);

   // Select the addressed lane of the returned word and extend it to 32 bits.
   always_comb begin
      byte_shift = bus_rdata_i >> {idx_q, 3'b000};
      half_shift = bus_rdata_i >> {idx_q[1], 4'b0000};
      load_ext   = bus_rdata_i;
      case (width_q)
         2'b00:   load_ext = {{24{~unsigned_q & byte_shift[7]}}, byte_shift[7:0]};
         2'b01:   load_ext = {{16{~unsigned_q & half_shift[15]}}, half_shift[15:0]};
         default: load_ext = bus_rdata_i;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         width_q       <= 2'b00;
         unsigned_q    <= 1'b0;
         idx_q         <= 2'b00;
         is_read_q     <= 1'b0;
         done_o        <= 1'b0;
         load_data_o   <= 32'h0;
         fault_o       <= 1'b0;
         fault_cause_o <= 2'b00;
         bus_req_o     <= 1'b0;
         bus_we_o      <= 1'b0;
         bus_addr_o    <= 32'h0;
         bus_wdata_o   <= 32'h0;
         bus_strb_o    <= 4'h0;
`ifdef MEM_TIMEOUT_EN
         wd_cnt        <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i && (mem_read_i || mem_write_i)) begin
                  width_q    <= mem_width_i;
                  unsigned_q <= mem_unsigned_i;
                  idx_q      <= mem_byte_idx_i;
                  is_read_q  <= mem_read_i;
                  if (bad_access) begin
                     state         <= DONE;
                     done_o        <= 1'b1;
                     fault_o       <= 1'b1;
                     fault_cause_o <= 2'b01;
                     load_data_o   <= 32'h0;
                  end else begin
                     state       <= REQ;
                     bus_req_o   <= 1'b1;
                     bus_we_o    <= mem_write_i;
                     bus_addr_o  <= mem_word_addr_i;
                     bus_wdata_o <= mem_write_data_i;
                     bus_strb_o  <= mem_write_i ? mem_strobe_i : 4'h0;
`ifdef MEM_TIMEOUT_EN
                     wd_cnt      <= '0;
`endif
                  end
               end
            end
            REQ: begin
               // An ack arriving in the watchdog's final cycle still completes normally.
               if (bus_ack_i) begin
                  state       <= DONE;
                  done_o      <= 1'b1;
                  bus_req_o   <= 1'b0;
                  bus_we_o    <= 1'b0;
                  bus_addr_o  <= 32'h0;
                  bus_wdata_o <= 32'h0;
                  bus_strb_o  <= 4'h0;
                  if (bus_err_i) begin
                     fault_o       <= 1'b1;
                     fault_cause_o <= 2'b10;
                     load_data_o   <= 32'h0;
                  end else begin
                     fault_o       <= 1'b0;
                     fault_cause_o <= 2'b00;
                     load_data_o   <= is_read_q ? load_ext : 32'h0;
                  end
               end
`ifdef MEM_TIMEOUT_EN
               else if (wd_cnt == WD_LIMIT) begin
                  state         <= DONE;
                  done_o        <= 1'b1;
                  fault_o       <= 1'b1;
                  fault_cause_o <= 2'b11;
                  load_data_o   <= 32'h0;
                  bus_req_o     <= 1'b0;
                  bus_we_o      <= 1'b0;
                  bus_addr_o    <= 32'h0;
                  bus_wdata_o   <= 32'h0;
                  bus_strb_o    <= 4'h0;
               end else begin
                  wd_cnt <= wd_cnt + TIMEOUT_W'(1);
               end
`endif
            end
            DONE: begin
               state         <= IDLE;
               done_o        <= 1'b0;
               fault_o       <= 1'b0;
               fault_cause_o <= 2'b00;
               load_data_o   <= 32'h0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, reset corner cases,
// and randomized accesses checked against a behavioural model.
module tb_mem_access_ctrl;

   localparam int TB_TIMEOUT = 4;
`ifdef MEM_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        mem_read_i = 1'b0;
   logic        mem_write_i = 1'b0;
   logic [1:0]  mem_width_i = 2'b00;
   logic        mem_unsigned_i = 1'b0;
   logic [1:0]  mem_byte_idx_i = 2'b00;
   logic [31:0] mem_word_addr_i = 32'h0;
   logic [31:0] mem_write_data_i = 32'h0;
   logic [3:0]  mem_strobe_i = 4'h0;
   logic        mem_illegal_i = 1'b0;
   logic        busy_o;
   logic        done_o;
   logic [31:0] load_data_o;
   logic        fault_o;
   logic [1:0]  fault_cause_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic [3:0]  bus_strb_o;
   logic        bus_ack_i = 1'b0;
   logic        bus_err_i = 1'b0;
   logic [31:0] bus_rdata_i = 32'h0;

   int n_vec = 0;
   int n_err = 0;

   mem_access_ctrl #(.TIMEOUT_W(8), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i),
      .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_width_i(mem_width_i),
      .mem_unsigned_i(mem_unsigned_i), .mem_byte_idx_i(mem_byte_idx_i),
      .mem_word_addr_i(mem_word_addr_i), .mem_write_data_i(mem_write_data_i),
      .mem_strobe_i(mem_strobe_i), .mem_illegal_i(mem_illegal_i),
      .busy_o(busy_o), .done_o(done_o), .load_data_o(load_data_o),
      .fault_o(fault_o), .fault_cause_o(fault_cause_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_wdata_o(bus_wdata_o), .bus_strb_o(bus_strb_o),
      .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_rdata_i(bus_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [1:0]  width;
      logic        uns;
      logic [1:0]  idx;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic        ill;
      int          waitc;
      logic [31:0] rdata;
      logic        err;
      logic [31:0] exp_data;
      logic        exp_fault;
      logic [1:0]  exp_cause;
      int          exp_done;
      int          exp_req;
   } vec_t;

   vec_t tbl [13];

   // Reference load extraction using byte arithmetic rather than bit slicing.
   function automatic logic [31:0] model_load(logic [1:0] width, logic uns,
                                              logic [1:0] idx, logic [31:0] rdata);
      longint b [4];
      longint val;
      for (int i = 0; i < 4; i++) b[i] = longint'((rdata >> (8 * i)) & 32'hFF);
      case (width)
         2'd0: begin
            val = b[idx];
            if (!uns && val >= 128) val = val - 256;
         end
         2'd1: begin
            val = b[{idx[1], 1'b0}] + 256 * b[{idx[1], 1'b1}];
            if (!uns && val >= 32768) val = val - 65536;
         end
         default: val = longint'(rdata);
      endcase
      return val[31:0];
   endfunction

   function automatic vec_t fill_expect(vec_t v);
      vec_t r = v;
      if (v.ill || (v.rd && v.wr) || v.width == 2'd3) begin
         r.exp_data = 32'h0; r.exp_fault = 1'b1; r.exp_cause = 2'd1;
         r.exp_done = 1; r.exp_req = 0;
      end else if (TO_EN && (v.waitc + 1 > TB_TIMEOUT)) begin
         r.exp_data = 32'h0; r.exp_fault = 1'b1; r.exp_cause = 2'd3;
         r.exp_done = TB_TIMEOUT + 1; r.exp_req = TB_TIMEOUT;
      end else begin
         r.exp_req  = v.waitc + 1;
         r.exp_done = v.waitc + 2;
         if (v.err) begin
            r.exp_data = 32'h0; r.exp_fault = 1'b1; r.exp_cause = 2'd2;
         end else begin
            r.exp_data  = v.rd ? model_load(v.width, v.uns, v.idx, v.rdata) : 32'h0;
            r.exp_fault = 1'b0; r.exp_cause = 2'd0;
         end
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Presents one access, plays the bus side, and compares the completion.
   task automatic applyStimulus(input vec_t v, input string tag);
      int          req_cnt = 0;
      int          done_k = 0;
      logic        stable_ok = 1'b1;
      logic [31:0] act_data = 32'h0;
      logic        act_fault = 1'b0;
      logic [1:0]  act_cause = 2'b00;
      @(negedge clk_i);
      req_valid_i = 1'b1; mem_read_i = v.rd; mem_write_i = v.wr;
      mem_width_i = v.width; mem_unsigned_i = v.uns; mem_byte_idx_i = v.idx;
      mem_word_addr_i = v.addr; mem_write_data_i = v.wdata;
      mem_strobe_i = v.wr ? v.strb : 4'h0; mem_illegal_i = v.ill;
      for (int k = 1; k <= 400 && done_k == 0; k++) begin
         @(negedge clk_i);
         req_valid_i = 1'b0;
         bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = $urandom;
         if (done_o) begin
            done_k = k; act_data = load_data_o; act_fault = fault_o; act_cause = fault_cause_o;
         end else begin
            if (busy_o !== 1'b1) stable_ok = 1'b0;
            if (bus_req_o) begin
               req_cnt++;
               if (bus_we_o !== v.wr || bus_addr_o !== v.addr ||
                   bus_strb_o !== (v.wr ? v.strb : 4'h0) ||
                   (v.wr && bus_wdata_o !== v.wdata)) stable_ok = 1'b0;
               if (req_cnt == v.waitc + 1) begin
                  bus_ack_i = 1'b1; bus_err_i = v.err; bus_rdata_i = v.rdata;
               end
            end
         end
      end
      checkOutput({tag, " done_latency"}, done_k, v.exp_done);
      checkOutput({tag, " req_cycles"}, req_cnt, v.exp_req);
      checkOutput({tag, " bus_stable"}, {31'b0, stable_ok}, 32'h1);
      checkOutput({tag, " load_data"}, act_data, v.exp_data);
      checkOutput({tag, " fault"}, {31'b0, act_fault}, {31'b0, v.exp_fault});
      checkOutput({tag, " cause"}, {30'b0, act_cause}, {30'b0, v.exp_cause});
      @(negedge clk_i);
      checkOutput({tag, " done_pulse_end"}, {31'b0, done_o}, 32'h0);
      checkOutput({tag, " idle_after"}, {30'b0, busy_o, bus_req_o}, 32'h0);
   endtask

   initial begin
      vec_t v;
      logic saw_done;
      tbl[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd3, 32'h0000_0100, 32'h0, 4'h0, 1'b0, 0,
                  32'h8012_3456, 1'b0, 32'hFFFF_FF80, 1'b0, 2'd0, 2, 1};
      tbl[1]  = '{1'b1, 1'b0, 2'd1, 1'b1, 2'd2, 32'h0000_0204, 32'h0, 4'h0, 1'b0, 3,
                  32'hBEEF_0000, 1'b0, 32'h0000_BEEF, 1'b0, 2'd0, 5, 4};
      tbl[2]  = '{1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 1'b0, 1,
                  32'h0, 1'b0, 32'h0, 1'b0, 2'd0, 3, 2};
      tbl[3]  = '{1'b1, 1'b0, 2'd1, 1'b0, 2'd1, 32'h0000_0300, 32'h0, 4'h0, 1'b1, 0,
                  32'h0, 1'b0, 32'h0, 1'b1, 2'd1, 1, 0};
      tbl[4]  = '{1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 32'h0000_0400, 32'h0, 4'h0, 1'b0, 0,
                  32'h1234_5678, 1'b1, 32'h0, 1'b1, 2'd2, 2, 1};
      tbl[5]  = '{1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 32'h0000_0500, 32'h0, 4'h0, 1'b0, 0,
                  32'h0000_A500, 1'b0, 32'h0000_00A5, 1'b0, 2'd0, 2, 1};
      tbl[6]  = '{1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 32'h0000_0600, 32'h0, 4'h0, 1'b0, 1,
                  32'h0000_7FFF, 1'b0, 32'h0000_7FFF, 1'b0, 2'd0, 3, 2};
      tbl[7]  = '{1'b1, 1'b0, 2'd1, 1'b0, 2'd2, 32'h0000_0700, 32'h0, 4'h0, 1'b0, 0,
                  32'h8001_1234, 1'b0, 32'hFFFF_8001, 1'b0, 2'd0, 2, 1};
      tbl[8]  = '{1'b1, 1'b0, 2'd3, 1'b0, 2'd0, 32'h0000_0800, 32'h0, 4'h0, 1'b0, 0,
                  32'h0, 1'b0, 32'h0, 1'b1, 2'd1, 1, 0};
      tbl[9]  = '{1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 32'h0000_0900, 32'h0, 4'hF, 1'b0, 0,
                  32'h0, 1'b0, 32'h0, 1'b1, 2'd1, 1, 0};
      tbl[10] = '{1'b0, 1'b1, 2'd0, 1'b0, 2'd1, 32'h0000_2000, 32'h5A5A_5A5A, 4'h2, 1'b0, 2,
                  32'h0, 1'b0, 32'h0, 1'b0, 2'd0, 4, 3};
      tbl[11] = '{1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 32'h0000_3000, 32'h1111_2222, 4'hF, 1'b0, 0,
                  32'h0, 1'b1, 32'h0, 1'b1, 2'd2, 2, 1};
      tbl[12] = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd2, 32'h0000_0C00, 32'h0, 4'h0, 1'b0, 0,
                  32'h007F_0000, 1'b0, 32'h0000_007F, 1'b0, 2'd0, 2, 1};

      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("reset_flags", {25'b0, busy_o, done_o, fault_o, fault_cause_o, bus_req_o, bus_we_o}, 32'h0);
      checkOutput("reset_load_data", load_data_o, 32'h0);
      checkOutput("reset_bus", bus_addr_o | bus_wdata_o | {28'b0, bus_strb_o}, 32'h0);
      rst_i = 1'b0;

      for (int i = 0; i < 13; i++) applyStimulus(tbl[i], $sformatf("tbl%0d", i));

      // Long stall: completes normally without a watchdog, aborts with cause 11 with one.
      v = tbl[0];
      v.waitc = 20;
      applyStimulus(fill_expect(v), "long_wait");

      // Reset while a load is waiting for ack: request drops, no completion follows.
      @(negedge clk_i);
      req_valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; mem_width_i = 2'd2;
      mem_illegal_i = 1'b0; mem_word_addr_i = 32'h0000_4000; mem_strobe_i = 4'h0;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      checkOutput("rst_mid_req_before", {31'b0, bus_req_o}, 32'h1);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      checkOutput("rst_mid_req_after", {29'b0, bus_req_o, busy_o, done_o}, 32'h0);
      rst_i = 1'b0;
      saw_done = 1'b0;
      repeat (4) begin
         @(negedge clk_i);
         if (done_o) saw_done = 1'b1;
      end
      checkOutput("rst_mid_req_no_done", {31'b0, saw_done}, 32'h0);

      for (int i = 0; i < 60; i++) begin
         int op = $urandom_range(0, 9);
         v = tbl[0];
         v.rd    = (op == 0) ? 1'b1 : op[0];
         v.wr    = (op == 0) ? 1'b1 : ~op[0];
         v.width = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         v.uns   = 1'($urandom_range(0, 1));
         v.idx   = 2'($urandom_range(0, 3));
         v.addr  = $urandom & 32'hFFFF_FFFC;
         v.wdata = $urandom;
         v.strb  = 4'($urandom_range(1, 15));
         v.ill   = ($urandom_range(0, 7) == 0);
         v.err   = ($urandom_range(0, 7) == 0);
         v.waitc = $urandom_range(0, 5);
         v.rdata = $urandom;
         applyStimulus(fill_expect(v), $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
